// File: rtl/dma_copy_master_pkg.sv
// Shared constants for the DMA copy master: register offsets, CTRL bit
// positions, engine state encoding and master-bus strobe values.
package dma_copy_master_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_BUSY   = 8;
    localparam int CTRL_DONE   = 9;

    localparam logic [3:0] WSTRB_RD = 4'h0;
    localparam logic [3:0] WSTRB_WR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_WR_REQ = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dma_regs.sv
// Slave register window of the DMA copy master: SRC/DST/LEN working registers,
// CTRL with sticky DONE, START qualification and the registered interrupt.
module dma_regs
    import dma_copy_master_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 select_i,
    input  logic [3:0]           wstrb_i,
    input  logic [1:0]           reg_sel_i,
    input  logic [31:0]          data_i,
    output logic                 ready_o,
    output logic [31:0]          data_o,
    input  logic                 busy_i,
    input  logic                 step_i,
    input  logic                 done_i,
    output logic                 start_o,
    output logic [31:0]          src_o,
    output logic [31:0]          dst_o,
    output logic [LEN_WIDTH-1:0] len_o,
    output logic                 irq_o
);

    logic                 ready_q;
    logic [31:0]          data_o_q;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 irq_en_q;
    logic                 done_q;
    logic                 irq_q;

    logic                 wr_en_s;
    logic                 ctrl_wr_s;
    logic                 start_acc_s;
    logic                 done_set_s;
    logic [31:0]          rdata_s;

    // Decode slave writes and qualify START against busy and a concurrent DONE set
    always_comb begin
        wr_en_s     = ready_q & select_i & (wstrb_i != 4'h0);
        ctrl_wr_s   = wr_en_s & (reg_sel_i == REG_CTRL);
        start_acc_s = ctrl_wr_s & data_i[CTRL_START] & ~busy_i & ~done_i;
        done_set_s  = done_i | (start_acc_s & (len_q == {LEN_WIDTH{1'b0}}));
        start_o     = start_acc_s & (len_q != {LEN_WIDTH{1'b0}});
    end

    // Read mux for the register window
    always_comb begin
        rdata_s = 32'h0;
        case (reg_sel_i)
            REG_SRC: rdata_s = src_q;
            REG_DST: rdata_s = dst_q;
            REG_LEN: rdata_s = {{(32-LEN_WIDTH){1'b0}}, len_q};
            REG_CTRL: begin
                rdata_s[CTRL_IRQ_EN] = irq_en_q;
                rdata_s[CTRL_BUSY]   = busy_i;
                rdata_s[CTRL_DONE]   = done_q;
            end
            default: rdata_s = 32'h0;
        endcase
    end

    // Slave handshake, working registers, DONE and irq state
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= 1'b0;
            data_o_q <= 32'h0;
            src_q    <= 32'h0;
            dst_q    <= 32'h0;
            len_q    <= {LEN_WIDTH{1'b0}};
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ready_q  <= select_i & ~ready_q;
            data_o_q <= (select_i & ~ready_q) ? rdata_s : 32'h0;

            if (step_i) begin
                src_q <= src_q + 32'd4;
                dst_q <= dst_q + 32'd4;
                len_q <= len_q - LEN_WIDTH'(1);
            end else if (wr_en_s & ~busy_i) begin
                case (reg_sel_i)
                    REG_SRC: src_q <= word_align(data_i);
                    REG_DST: dst_q <= word_align(data_i);
                    REG_LEN: len_q <= data_i[LEN_WIDTH-1:0];
                    default: len_q <= len_q;
                endcase
            end

            if (ctrl_wr_s) begin
                irq_en_q <= data_i[CTRL_IRQ_EN];
            end

            // A DONE set outranks a same-cycle write-1-to-clear
            if (done_set_s) begin
                done_q <= 1'b1;
            end else if (start_o) begin
                done_q <= 1'b0;
            end else if (ctrl_wr_s & data_i[CTRL_DONE]) begin
                done_q <= 1'b0;
            end

            irq_q <= done_q & irq_en_q;
        end
    end

    assign ready_o = ready_q;
    assign data_o  = data_o_q;
    assign src_o   = src_q;
    assign dst_o   = dst_q;
    assign len_o   = len_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/dma_copy_master.sv
// Memory-to-memory word copy engine: alternates read and write requests on the
// master port with a one-cycle idle gap between every transaction.
module dma_copy_master
    import dma_copy_master_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    state_e               state_q;
    state_e               next_q;
    logic                 m_valid_q;
    logic [31:0]          m_addr_q;
    logic [31:0]          m_wdata_q;
    logic [3:0]           m_wstrb_q;

    logic                 start_s;
    logic                 step_s;
    logic                 last_s;
    logic [31:0]          src_s;
    logic [31:0]          dst_s;
    logic [LEN_WIDTH-1:0] len_s;
    logic                 unused_s;

    assign unused_s = &{1'b0, addr[1:0]};
    assign step_s   = (state_q == ST_WR_REQ) & m_ready;
    assign last_s   = step_s & (len_s == LEN_WIDTH'(1));

    dma_regs #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .select_i  (select),
        .wstrb_i   (wstrb),
        .reg_sel_i (addr[3:2]),
        .data_i    (data_i),
        .ready_o   (ready),
        .data_o    (data_o),
        .busy_i    (state_q != ST_IDLE),
        .step_i    (step_s),
        .done_i    (last_s),
        .start_o   (start_s),
        .src_o     (src_s),
        .dst_o     (dst_s),
        .len_o     (len_s),
        .irq_o     (irq)
    );

    // Copy engine FSM with registered master-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            next_q    <= ST_IDLE;
            m_valid_q <= 1'b0;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            m_wstrb_q <= WSTRB_RD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q   <= ST_RD_REQ;
                        m_valid_q <= 1'b1;
                        m_addr_q  <= src_s;
                        m_wstrb_q <= WSTRB_RD;
                    end
                end
                ST_RD_REQ: begin
                    if (m_ready) begin
                        state_q   <= ST_GAP;
                        next_q    <= ST_WR_REQ;
                        m_valid_q <= 1'b0;
                        m_wdata_q <= m_rdata;
                    end
                end
                ST_WR_REQ: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= last_s ? ST_IDLE : ST_GAP;
                        next_q    <= ST_RD_REQ;
                    end
                end
                // SRC/DST already reflect the last step when leaving the gap
                ST_GAP: begin
                    state_q   <= next_q;
                    m_valid_q <= 1'b1;
                    if (next_q == ST_WR_REQ) begin
                        m_addr_q  <= dst_s;
                        m_wstrb_q <= WSTRB_WR;
                    end else begin
                        m_addr_q  <= src_s;
                        m_wstrb_q <= WSTRB_RD;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_dma_copy_master.sv
// Self-checking bench for dma_copy_master: register window, copies against a
// transaction-level reference, wait states, busy protection and mid-copy reset.
module tb_dma_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        select;
    logic [3:0]  wstrb;
    logic [3:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [67:0] obs_q[$];
    logic [31:0] mem [logic [31:0]];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    bit          req_open = 1'b0;
    logic [67:0] cap_v;

    dma_copy_master #(.LEN_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
        .data_i(data_i), .ready(ready), .data_o(data_o), .m_valid(m_valid),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready),
        .m_rdata(m_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : mem_init(a);
    endfunction

    // Memory slave: wait_cfg wait cycles per request, logs every completed transaction
    always @(negedge clk) begin
        if (reset || !m_valid) begin
            m_ready  = 1'b0;
            req_open = 1'b0;
            m_rdata  = $urandom();
        end else begin
            if (!req_open) begin
                req_open = 1'b1;
                wait_cnt = 0;
                cap_v    = {m_addr, m_wstrb, m_wdata};
            end else begin
                check_eq("hold_stable", {m_addr, m_wstrb, m_wdata}, cap_v);
            end
            if (wait_cnt >= wait_cfg) begin
                m_ready  = 1'b1;
                req_open = 1'b0;
                if (m_wstrb == 4'hF) begin
                    mem[m_addr] = m_wdata;
                    obs_q.push_back({m_addr, m_wstrb, m_wdata});
                end else begin
                    m_rdata = rd_word(m_addr);
                    obs_q.push_back({m_addr, m_wstrb, 32'h0});
                end
            end else begin
                m_ready = 1'b0;
                m_rdata = $urandom();
                wait_cnt++;
            end
        end
    end

    task automatic reg_access(input logic [1:0] r, input logic [3:0] s,
                              input logic [31:0] d, output logic [31:0] q);
        @(negedge clk);
        select = 1'b1; wstrb = s; addr = {r, 2'b00}; data_i = d;
        @(negedge clk);
        check_eq("ready_hi", ready, 1'b1);
        q = data_o;
        @(negedge clk);
        check_eq("ready_lo", ready, 1'b0);
        select = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        reg_access(r, 4'hF, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
        logic [31:0] q;
        reg_access(r, 4'h0, 32'h0, q);
        check_eq(tag, q, exp);
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                              input int len, input int wt);
        wait_cfg = wt;
        obs_q.delete();
        wr(2'd0, src);
        wr(2'd1, dst);
        wr(2'd2, 32'(len));
        wr(2'd3, 32'h3);
    endtask

    task automatic wait_irq(input int budget);
        int k = 0;
        while (irq !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("irq_done", irq, 1'b1);
    endtask

    // Reference: LEN read/write pairs, each write carries the word read before it
    task automatic check_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        check_eq("txn_count", obs_q.size(), 2 * len);
        for (int i = 0; i < len; i++) begin
            logic [31:0] sa;
            logic [31:0] da;
            sa = src + 32'(4 * i);
            da = dst + 32'(4 * i);
            if (2 * i < obs_q.size())
                check_eq("rd_txn", obs_q[2 * i], {sa, 4'h0, 32'h0});
            if (2 * i + 1 < obs_q.size())
                check_eq("wr_txn", obs_q[2 * i + 1], {da, 4'hF, mem_init(sa)});
        end
    endtask

    task automatic end_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int budget);
        wait_irq(budget);
        check_copy(src, dst, len);
        rd_chk("src_final", 2'd0, src + 32'(4 * len));
        rd_chk("dst_final", 2'd1, dst + 32'(4 * len));
        rd_chk("len_final", 2'd2, 32'h0);
        rd_chk("ctrl_done", 2'd3, 32'h202);
        wr(2'd3, 32'h200);
        @(negedge clk);
        check_eq("irq_clr", irq, 1'b0);
        rd_chk("ctrl_clr", 2'd3, 32'h0);
    endtask

    initial begin
        bit found;
        reset = 1'b1; select = 1'b0; wstrb = 4'h0; addr = 4'h0; data_i = 32'h0;
        m_ready = 1'b0; m_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", ready, 1'b0);
        check_eq("rst_data_o", data_o, 32'h0);
        check_eq("rst_m_valid", m_valid, 1'b0);
        check_eq("rst_m_addr", m_addr, 32'h0);
        check_eq("rst_m_wdata", m_wdata, 32'h0);
        check_eq("rst_m_wstrb", m_wstrb, 4'h0);
        check_eq("rst_irq", irq, 1'b0);
        reset = 1'b0;
        for (int r = 0; r < 4; r++) rd_chk("rst_reg", 2'(r), 32'h0);

        // Register access and alignment/width rules
        wr(2'd0, 32'h0000_1003); rd_chk("src_align", 2'd0, 32'h0000_1000);
        wr(2'd2, 32'h5);         rd_chk("len_rw", 2'd2, 32'h5);
        wr(2'd2, 32'hFFFF_1234); rd_chk("len_trunc", 2'd2, 32'h1234);
        wr(2'd1, 32'hABCD_EF07); rd_chk("dst_align", 2'd1, 32'hABCD_EF04);
        wr(2'd3, 32'h0000_0102); rd_chk("ctrl_rw", 2'd3, 32'h2);
        wr(2'd3, 32'h0);

        // Three-word copy, zero-wait: valid every other cycle, DONE 12 cycles on
        start_copy(32'h100, 32'h800, 3, 0);
        for (int k = 1; k <= 13; k++) begin
            check_eq("mvalid_pattern", m_valid, (k <= 11 && (k % 2) == 1) ? 1'b1 : 1'b0);
            check_eq("irq_timing", irq, (k >= 13) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        end_copy(32'h100, 32'h800, 3, 50);

        // Wait states on every transaction
        start_copy(32'h400, 32'hC00, 5, 3);
        end_copy(32'h400, 32'hC00, 5, 200);

        // LEN=0 start: no traffic, DONE then irq one cycle later
        obs_q.delete();
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            check_eq("len0_no_valid", m_valid, 1'b0);
            check_eq("len0_irq", irq, (k >= 2) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        check_eq("len0_txn", obs_q.size(), 0);
        rd_chk("len0_ctrl", 2'd3, 32'h202);
        wr(2'd3, 32'h200);
        @(negedge clk);
        check_eq("len0_irq_clr", irq, 1'b0);

        // Address wrap past 32'hFFFF_FFFC
        start_copy(32'hFFFF_FFF8, 32'h7000_0000, 3, 1);
        end_copy(32'hFFFF_FFF8, 32'h7000_0000, 3, 100);

        // Busy protection: SRC/LEN writes and a second START are ignored
        start_copy(32'h2000, 32'h9000, 4, 3);
        rd_chk("ctrl_busy", 2'd3, 32'h102);
        wr(2'd0, 32'hDEAD_BEE0);
        wr(2'd2, 32'h9);
        wr(2'd3, 32'h3);
        end_copy(32'h2000, 32'h9000, 4, 300);

        // Randomized copies
        for (int it = 0; it < 4; it++) begin
            logic [31:0] s;
            logic [31:0] d;
            int          n;
            int          w;
            s = 32'h1000_0000 | ($urandom() & 32'h000F_FFFC);
            d = 32'h5000_0000 | ($urandom() & 32'h000F_FFFC);
            n = $urandom_range(1, 6);
            w = $urandom_range(0, 2);
            start_copy(s, d, n, w);
            end_copy(s, d, n, 200);
        end

        // Reset during a write request
        start_copy(32'h3000, 32'hA000, 4, 3);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_valid === 1'b1 && m_wstrb === 4'hF) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("rst_wr_seen", found, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_m_valid", m_valid, 1'b0);
        check_eq("midrst_irq", irq, 1'b0);
        reset = 1'b0;
        wait_cfg = 0;
        for (int r = 0; r < 4; r++) rd_chk("midrst_reg", 2'(r), 32'h0);
        start_copy(32'h3000, 32'hA000, 2, 0);
        end_copy(32'h3000, 32'hA000, 2, 50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
